// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader: FSM state encoding,
// fixed word geometry and the byte-to-instruction packing helpers.
package loader_pkg;

   localparam int INSTR_W         = 19;
   localparam int ADDR_W          = 12;
   localparam int BYTES_PER_INSTR = 3;

   typedef enum logic [2:0] {
      IDLE,
      S_ADDR_LO,
      S_CNT_HI,
      S_CNT_LO,
      S_B0,
      S_B1,
      S_B2,
      DONE
   } state_t;

   // Only the low three bits of B0 carry payload; the rest must be zero.
   function automatic logic [INSTR_W-1:0] assemble_instr(input logic [7:0] b0,
                                                         input logic [7:0] b1,
                                                         input logic [7:0] b2);
      return {b0[2:0], b1, b2};
   endfunction

   function automatic logic b0_malformed(input logic [7:0] b0);
      return |b0[7:3];
   endfunction

endpackage

// File: rtl/instruction_loader.sv
// Byte-stream program loader: parses an address/count header, packs 3-byte
// groups into instructions and writes them to instruction memory in sequence.
module instruction_loader #(
   parameter int ADDR_W  = 12,
   parameter int INSTR_W = 19
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [INSTR_W-1:0] mem_wdata,
   output logic               busy,
   output logic               done,
   output logic               err
);
   import loader_pkg::*;

   // Handshake: a byte moves on a rising edge where in_valid && in_ready are
   // both high; in_valid may drop at any time, stalling the FSM indefinitely.
   state_t            state;
   state_t            state_nxt;
   logic              accept;
   logic [7:0]        hold_q;     // ADDR_HI, then CNT_HI, then B0 of each group
   logic [7:0]        byte1_q;
   logic [ADDR_W-1:0] addr_q;
   logic [11:0]       remain_q;

   assign accept = in_valid & in_ready;

   always_comb begin
      state_nxt = state;
      if (accept) begin
         unique case (state)
            IDLE:      state_nxt = S_ADDR_LO;
            S_ADDR_LO: state_nxt = S_CNT_HI;
            S_CNT_HI:  state_nxt = S_CNT_LO;
            S_CNT_LO:  state_nxt = ({hold_q[3:0], in_data} == 12'd0) ? DONE : S_B0;
            S_B0:      state_nxt = S_B1;
            S_B1:      state_nxt = S_B2;
            S_B2:      state_nxt = (remain_q == 12'd1) ? DONE : S_B0;
            default:   state_nxt = state;
         endcase
      end
      if (state == DONE) begin
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         hold_q    <= 8'd0;
         byte1_q   <= 8'd0;
         addr_q    <= '0;
         remain_q  <= 12'd0;
      end else begin
         state    <= state_nxt;
         // Status flags are derived from the next state so they line up with it.
         in_ready <= (state_nxt != DONE);
         busy     <= (state_nxt != IDLE);
         done     <= (state_nxt == DONE);
         mem_we   <= 1'b0;
         if (accept) begin
            unique case (state)
               IDLE: begin
                  hold_q <= in_data;
                  err    <= 1'b0;
               end
               S_ADDR_LO: addr_q   <= ADDR_W'({hold_q[3:0], in_data});
               S_CNT_HI:  hold_q   <= in_data;
               S_CNT_LO:  remain_q <= {hold_q[3:0], in_data};
               S_B0: begin
                  hold_q <= in_data;
                  if (b0_malformed(in_data)) begin
                     err <= 1'b1;
                  end
               end
               S_B1: byte1_q <= in_data;
               S_B2: begin
                  mem_we    <= 1'b1;
                  mem_addr  <= addr_q;
                  mem_wdata <= INSTR_W'(assemble_instr(hold_q, byte1_q, in_data));
                  addr_q    <= addr_q + 1'b1;
                  remain_q  <= remain_q - 12'd1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader with a write scoreboard fed at stimulus
// time and drained by a negedge monitor on mem_we.
module tb_instruction_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  in_data = 8'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [18:0] mem_wdata;
   logic        busy;
   logic        done;
   logic        err;

   int          compared = 0;
   int          mismatched = 0;
   logic [30:0] exp_q[$];
   logic [11:0] exp_addr = 12'd0;
   bit          use_gaps = 1'b0;
   logic [7:0]  r0[5];
   logic [7:0]  r1[5];
   logic [7:0]  r2[5];

   instruction_loader #(.ADDR_W(12), .INSTR_W(19)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) tick();
   endtask

   // Leaves in_valid high on return so a following byte can go back-to-back.
   task automatic send_byte(input logic [7:0] b);
      bit taken;
      int n;
      if (use_gaps) begin
         repeat ($urandom_range(0, 3)) begin
            in_valid = 1'b0;
            tick();
         end
      end
      in_data  = b;
      in_valid = 1'b1;
      taken    = 1'b0;
      n        = 0;
      while (!taken && n < 200) begin
         taken = in_ready;
         tick();
         n++;
      end
      if (!taken) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_header(input logic [11:0] a, input logic [11:0] c);
      logic [3:0] junk;
      exp_addr = a;
      junk = 4'($urandom_range(0, 15));
      send_byte({junk, a[11:8]});
      chk("busy_after_addr_hi", 32'(busy), 32'd1);
      send_byte(a[7:0]);
      junk = 4'($urandom_range(0, 15));
      send_byte({junk, c[11:8]});
      send_byte(c[7:0]);
   endtask

   task automatic send_instr(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      exp_q.push_back({exp_addr, b0[2:0], b1, b2});
      exp_addr = exp_addr + 12'd1;
      send_byte(b0);
      send_byte(b1);
      send_byte(b2);
   endtask

   task automatic chk_done_write(input string tag);
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_we"}, 32'(mem_we), 32'd1);
      chk({tag, "_ready_low"}, 32'(in_ready), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
   endtask

   always @(negedge clk) begin
      logic [30:0] e;
      if (mem_we) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("sb_addr", 32'(mem_addr), 32'(e[30:19]));
            chk("sb_wdata", 32'(mem_wdata), 32'(e[18:0]));
         end
      end
   end

   initial begin
      #500000;
      chk("global_timeout", 32'd0, 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $fatal(1, "FAIL global_timeout");
   end

   initial begin
      repeat (3) tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata", 32'(mem_wdata), 32'd0);
      rst = 1'b0;
      tick();
      chk("ready_after_rst", 32'(in_ready), 32'd1);

      // Basic two-word frame at address 7.
      send_header(12'h007, 12'd2);
      send_instr(8'h00, 8'hC6, 8'h26);
      send_instr(8'h00, 8'h83, 8'h0F);
      chk_done_write("t1");
      chk("t1_last_addr", 32'(mem_addr), 32'd8);
      chk("t1_last_data", 32'(mem_wdata), 32'h0830F);
      chk("t1_err", 32'(err), 32'd0);
      idle(1);
      chk("t1_done_clear", 32'(done), 32'd0);
      chk("t1_busy_clear", 32'(busy), 32'd0);
      chk("t1_ready_back", 32'(in_ready), 32'd1);

      // Header-only frame.
      send_header(12'h100, 12'd0);
      chk("t2_done", 32'(done), 32'd1);
      chk("t2_no_we", 32'(mem_we), 32'd0);
      chk("t2_ready_low", 32'(in_ready), 32'd0);
      idle(1);
      chk("t2_done_clear", 32'(done), 32'd0);
      chk("t2_busy_clear", 32'(busy), 32'd0);

      // Address wrap 4095 -> 0.
      send_header(12'hFFF, 12'd2);
      send_instr(8'h01, 8'h23, 8'h45);
      send_instr(8'h07, 8'hFF, 8'hFF);
      chk_done_write("t3");
      chk("t3_wrap_addr", 32'(mem_addr), 32'd0);
      idle(1);

      // Malformed B0: sticky err, word still written with B0[2:0].
      send_header(12'h020, 12'd1);
      send_instr(8'hFA, 8'h12, 8'h34);
      chk_done_write("t4");
      chk("t4_err_set", 32'(err), 32'd1);
      chk("t4_wdata", 32'(mem_wdata), 32'h21234);
      idle(2);
      chk("t4_err_sticky", 32'(err), 32'd1);

      // Gap-free 5-word frame; ADDR_HI clears err.
      for (int i = 0; i < 5; i++) begin
         r0[i] = 8'($urandom_range(0, 7));
         r1[i] = 8'($urandom_range(0, 255));
         r2[i] = 8'($urandom_range(0, 255));
      end
      exp_addr = 12'h040;
      send_byte(8'h00);
      chk("t5_err_cleared", 32'(err), 32'd0);
      send_byte(8'h40);
      send_byte(8'h00);
      send_byte(8'h05);
      for (int i = 0; i < 5; i++) send_instr(r0[i], r1[i], r2[i]);
      chk_done_write("t5");
      chk("t5_last_addr", 32'(mem_addr), 32'h044);

      // in_valid stays high through DONE: ADDR_HI waits for IDLE, then same frame with gaps.
      exp_addr = 12'h040;
      send_byte(8'h00);
      chk("t6_busy_again", 32'(busy), 32'd1);
      use_gaps = 1'b1;
      send_byte(8'h40);
      send_byte(8'h00);
      send_byte(8'h05);
      for (int i = 0; i < 5; i++) send_instr(r0[i], r1[i], r2[i]);
      chk_done_write("t6");
      chk("t6_last_addr", 32'(mem_addr), 32'h044);
      use_gaps = 1'b0;
      idle(1);

      // Reset lands on the B2 accept edge: write must be dropped.
      send_header(12'h300, 12'd1);
      send_byte(8'h05);
      send_byte(8'h66);
      in_data  = 8'h77;
      in_valid = 1'b1;
      chk("t7_ready_before_rst", 32'(in_ready), 32'd1);
      rst = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("t7_no_we", 32'(mem_we), 32'd0);
      chk("t7_in_ready", 32'(in_ready), 32'd0);
      chk("t7_busy", 32'(busy), 32'd0);
      chk("t7_done", 32'(done), 32'd0);
      chk("t7_addr", 32'(mem_addr), 32'd0);
      chk("t7_wdata", 32'(mem_wdata), 32'd0);
      rst = 1'b0;
      tick();
      chk("t7_ready_back", 32'(in_ready), 32'd1);

      // Clean reload after reset.
      send_header(12'h300, 12'd2);
      send_instr(8'h05, 8'h66, 8'h77);
      send_instr(8'h02, 8'hAB, 8'hCD);
      chk_done_write("t8");
      chk("t8_last_data", 32'(mem_wdata), 32'h2ABCD);
      idle(3);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
